draw_character: RTL and testbench
=================================

Name: draw_character

Overview:
- Sprite renderer that consumes the character controller's position (value_x/value_y), character_state and facing outputs.
- Overlays the player sprite onto the VGA stream from a sprite ROM. Sits directly after the controller in the vga_if chain.
- Position and state are sampled once per frame, so the sprite never tears mid-frame.
- Runs a per-frame animation counter for the walk cycle.

Parameters:
- CHAR_W, 48, sprite width in pixels.
- CHAR_H, 64, sprite height in pixels.
- TRANSPARENT, 12'hF0F, ROM colour treated as see-through (input rgb passes).
- ANIM_FRAMES, 8, number of video frames per walk-animation step.
- X_RST, 64, shadow x after reset.
- Y_RST, 641, shadow y after reset (768-63-64).

Ports:
- clk  in  1  pixel clock, 65 MHz.
- rst  in  1  synchronous, active-high reset.
- xpos  in  12  sprite top-left x (controller value_x).
- ypos  in  12  sprite top-left y (controller value_y).
- character_state  in  2  00 idle, 01 walk/jump-prep/jump, 10 falling, 11 reserved.
- facing  in  1  1 = facing right (native ROM orientation), 0 = mirrored.
- rom_addr  out  14  sprite ROM address, registered.
- rom_data  in  12  sprite ROM pixel; valid exactly 1 clk after rom_addr.
- vga_in  vga_if.in  -  upstream timing and rgb.
- vga_out  vga_if.out  -  downstream timing and rgb.

Behaviour:
- Reset, synchronous, active-high on clk: all vga_out fields 0, rom_addr 0, x_sh=X_RST, y_sh=Y_RST, st_sh=00, face_sh=1, anim_cnt=0, anim_ph=0, vblnk_d=0, both pipeline stages cleared. Reset mid-line: output goes to 0 on the next clk; normal output resumes on the first frame after release.
- Frame sampling:
  - vblnk_d is vga_in.vblnk delayed 1 clk.
  - On the vblank rising edge (vga_in.vblnk=1 and vblnk_d=0), x_sh, y_sh, st_sh and face_sh capture the inputs.
  - No shadow register changes at any other time.
- Animation:
  - On the same vblank edge, if st_sh (pre-update value) = 01: anim_cnt increments. When anim_cnt=ANIM_FRAMES-1, anim_cnt wraps to 0 and anim_ph toggles.
  - For any other state, anim_cnt and anim_ph clear to 0.
- Sprite frame select: st 00 -> 0; st 01 -> 1+anim_ph; st 10 -> 3; st 11 -> 0.
- Stage 1 (clk edge 1):
  - dx=hcount-x_sh, dy=vcount-y_sh, computed at 13 bits.
  - in_box = hcount>=x_sh, hcount<x_sh+CHAR_W (13-bit sum, no wrap at 4095), vcount>=y_sh, vcount<y_sh+CHAR_H, and neither hblnk nor vblnk.
  - col = face_sh ? dx : CHAR_W-1-dx.
  - rom_addr = frame*CHAR_W*CHAR_H + dy*CHAR_W + col when in_box, else 0.
  - Timing fields and rgb are registered, and in_box is delayed alongside them.
- Stage 2 (clk edge 2): vga_out.rgb = (in_box_d && rom_data!=TRANSPARENT) ? rom_data : rgb_d. All other vga_out fields are the stage-1 copies.
- Latency: exactly 2 clk for every vga_if field. Timing alignment between fields is preserved.
- Clipping: sprite parts beyond 1023/767 are never drawn because of the blank gating. A negative position cannot occur (12-bit unsigned).
- Simultaneous events: xpos/ypos changing on the vblank-edge cycle -> the new values are captured. A change one cycle later waits a full frame.
- The sprite must never emit 12'h2B4: any ROM pixel equal to 12'h2B4 is output as 12'h2B5, so the controller's platform-colour collision detection is never triggered.

Test Plan:
- Reset, then frame with xpos=100, ypos=200, state 00, facing 1 -> after the vblank edge, rom_addr at (hcount=100, vcount=200) is 0; at (147,263) it is 3071. Outside the box, rom_addr=0 and rgb passes unchanged with 2 clk delay.
- Same position, facing 0 -> at hcount=100, vcount=200 rom_addr=47; at hcount=147 rom_addr=0.
- State 01 held for 16 frames, ANIM_FRAMES=8 -> frame base 3072 for frames 1-8, 6144 for frames 9-16. Switching to state 10 -> base 9216, anim_ph=0.
- xpos changed mid-frame at vcount=300 -> no change in drawn position until after the next vblank rising edge.
- ROM returns 12'hF0F over a vga_in.rgb=12'h2B4 background -> output 12'h2B4. ROM returns 12'h2B4 -> output 12'h2B5.
- xpos=1000 -> drawing stops at hcount=1023 and no pixel appears in hblank; assert rst at hcount=1010 -> vga_out all zero on the next clk.

Source files
------------

// File: rtl/draw_character_if.sv
// vga_if: VGA timing and colour bundle passed along the video chain.
//   vcount/hcount : pixel coordinates (11 bit, 1024x768 @ 65 MHz timing)
//   vsync/hsync   : sync pulses
//   vblnk/hblnk   : blanking flags
//   rgb           : 4:4:4 pixel colour
//   modport in    : consumer view (all fields inputs)
//   modport out   : producer view (all fields outputs)
interface vga_if;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/draw_character.sv
// draw_character: overlays the animated player sprite onto the VGA stream.
// Position, state and facing are shadowed once per frame on the vblank
// rising edge so the sprite cannot tear. A two-stage pipeline issues the
// sprite ROM address, then muxes the returned pixel over the background.
// Ports:
//   clk, rst         : pixel clock, synchronous active-high reset
//   xpos, ypos       : sprite top-left corner from the controller
//   character_state  : 00 idle, 01 walk, 10 falling, 11 reserved
//   facing           : 1 native ROM orientation, 0 horizontally mirrored
//   rom_addr         : registered sprite ROM address
//   rom_data         : ROM pixel, valid one clock after rom_addr
//   vga_in, vga_out  : video stream, vga_out delayed by exactly 2 clocks
module draw_character #(
  parameter int          CHAR_W      = 48,
  parameter int          CHAR_H      = 64,
  parameter logic [11:0] TRANSPARENT = 12'hF0F,
  parameter int          ANIM_FRAMES = 8,
  parameter int          X_RST       = 64,
  parameter int          Y_RST       = 641
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic [1:0]  character_state,
  input  logic        facing,
  output logic [13:0] rom_addr,
  input  logic [11:0] rom_data,
  vga_if.in           vga_in,
  vga_if.out          vga_out
);

  localparam int                CNT_W    = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ANIM_FRAMES - 1);
  localparam logic [13:0]       FRAME_SZ = 14'(CHAR_W * CHAR_H);
  localparam logic [13:0]       ROW_SZ   = 14'(CHAR_W);
  localparam logic [12:0]       W13      = 13'(CHAR_W);
  localparam logic [12:0]       H13      = 13'(CHAR_H);
  localparam logic [12:0]       WM1      = 13'(CHAR_W - 1);

  // The platform colour is reserved for collision detection downstream;
  // nudge it by one LSB so the sprite can never be mistaken for a platform.
  function automatic logic [11:0] sprite_pixel(input logic [11:0] pix);
    return (pix == 12'h2B4) ? 12'h2B5 : pix;
  endfunction

  logic [11:0]      x_sh, y_sh;
  logic [1:0]       st_sh;
  logic             face_sh;
  logic [CNT_W-1:0] anim_cnt;
  logic             anim_ph;
  logic             vblnk_d;
  logic             frame_edge;

  assign frame_edge = vga_in.vblnk && !vblnk_d;

  // Frame-rate shadow registers and walk-cycle animation. The animation
  // decision looks at the state shown during the frame that just ended.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_sh     <= 12'(X_RST);
      y_sh     <= 12'(Y_RST);
      st_sh    <= 2'b00;
      face_sh  <= 1'b1;
      anim_cnt <= '0;
      anim_ph  <= 1'b0;
      vblnk_d  <= 1'b0;
    end else begin
      vblnk_d <= vga_in.vblnk;
      if (frame_edge) begin
        x_sh    <= xpos;
        y_sh    <= ypos;
        st_sh   <= character_state;
        face_sh <= facing;
        if (st_sh == 2'b01) begin
          if (anim_cnt == CNT_LAST) begin
            anim_cnt <= '0;
            anim_ph  <= ~anim_ph;
          end else begin
            anim_cnt <= anim_cnt + 1'b1;
          end
        end else begin
          anim_cnt <= '0;
          anim_ph  <= 1'b0;
        end
      end
    end
  end

  // ---- stage p0: box test and address arithmetic (combinational) ----
  logic [12:0] hc_p0, vc_p0, x_p0, y_p0, dx_p0, dy_p0, col_p0;
  logic        in_box_p0;
  logic [1:0]  frame_p0;
  logic [13:0] addr_p0;

  always_comb begin
    hc_p0  = {2'b00, vga_in.hcount};
    vc_p0  = {2'b00, vga_in.vcount};
    x_p0   = {1'b0, x_sh};
    y_p0   = {1'b0, y_sh};
    dx_p0  = hc_p0 - x_p0;
    dy_p0  = vc_p0 - y_p0;
    // 13-bit right/bottom bounds so a sprite near x=4095 cannot wrap.
    in_box_p0 = (hc_p0 >= x_p0) && (hc_p0 < x_p0 + W13) &&
                (vc_p0 >= y_p0) && (vc_p0 < y_p0 + H13) &&
                !vga_in.hblnk && !vga_in.vblnk;
    col_p0 = face_sh ? dx_p0 : (WM1 - dx_p0);
    case (st_sh)
      2'b01:   frame_p0 = 2'd1 + {1'b0, anim_ph};
      2'b10:   frame_p0 = 2'd3;
      default: frame_p0 = 2'd0;
    endcase
    addr_p0 = 14'd0;
    if (in_box_p0)
      addr_p0 = 14'(frame_p0) * FRAME_SZ + 14'(dy_p0) * ROW_SZ + 14'(col_p0);
  end

  // ---- stage p1: ROM address issued, video delayed to meet ROM data ----
  logic [10:0] vcount_p1, hcount_p1;
  logic        vsync_p1, vblnk_p1, hsync_p1, hblnk_p1, in_box_p1;
  logic [11:0] rgb_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr  <= '0;
      vcount_p1 <= '0;
      vsync_p1  <= 1'b0;
      vblnk_p1  <= 1'b0;
      hcount_p1 <= '0;
      hsync_p1  <= 1'b0;
      hblnk_p1  <= 1'b0;
      rgb_p1    <= '0;
      in_box_p1 <= 1'b0;
    end else begin
      rom_addr  <= addr_p0;
      vcount_p1 <= vga_in.vcount;
      vsync_p1  <= vga_in.vsync;
      vblnk_p1  <= vga_in.vblnk;
      hcount_p1 <= vga_in.hcount;
      hsync_p1  <= vga_in.hsync;
      hblnk_p1  <= vga_in.hblnk;
      rgb_p1    <= vga_in.rgb;
      in_box_p1 <= in_box_p0;
    end
  end

  // ---- stage p2: sprite pixel over background ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_out.vcount <= '0;
      vga_out.vsync  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
      vga_out.hcount <= '0;
      vga_out.hsync  <= 1'b0;
      vga_out.hblnk  <= 1'b0;
      vga_out.rgb    <= '0;
    end else begin
      vga_out.vcount <= vcount_p1;
      vga_out.vsync  <= vsync_p1;
      vga_out.vblnk  <= vblnk_p1;
      vga_out.hcount <= hcount_p1;
      vga_out.hsync  <= hsync_p1;
      vga_out.hblnk  <= hblnk_p1;
      vga_out.rgb    <= (in_box_p1 && rom_data != TRANSPARENT) ?
                        sprite_pixel(rom_data) : rgb_p1;
    end
  end

endmodule

// File: tb/tb_draw_character.sv
// Testbench for draw_character: per-pixel stimulus with a scoreboard of
// expected rom_addr (1 clk later) and vga_out (2 clk later) values.
module tb_draw_character;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] xpos = '0, ypos = '0;
  logic [1:0]  character_state = '0;
  logic        facing = 1'b1;
  logic [13:0] rom_addr;
  logic [11:0] rom_data = '0;

  vga_if vin ();
  vga_if vout ();

  draw_character dut (
    .clk             (clk),
    .rst             (rst),
    .xpos            (xpos),
    .ypos            (ypos),
    .character_state (character_state),
    .facing          (facing),
    .rom_addr        (rom_addr),
    .rom_data        (rom_data),
    .vga_in          (vin),
    .vga_out         (vout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] addr;
    string       name;
  } addr_rec_t;

  typedef struct {
    logic [10:0] hc, vc;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb;
    string       name;
  } out_rec_t;

  typedef struct {
    logic        nf;
    logic [11:0] x, y;
    logic [1:0]  st;
    logic        f;
    logic [10:0] hc, vc;
    logic        hb;
    logic [11:0] rgb, rom;
    logic [13:0] ea;
    logic [11:0] er;
  } vec_t;

  addr_rec_t   addr_q[$];
  out_rec_t    out_q[$];
  out_rec_t    prev_out;
  logic [11:0] prev_rom = '0;
  logic [11:0] nx = '0, ny = '0;
  logic [1:0]  nst = '0;
  logic        nf = 1'b1;
  int          errors = 0;
  int          checks = 0;
  vec_t        tbl[14];

  task automatic check_pending();
    addr_rec_t a;
    out_rec_t  o;
    if (addr_q.size() > 0) begin
      a = addr_q.pop_front();
      checks++;
      if (rom_addr !== a.addr) begin
        errors++;
        $display("FAIL %s rom_addr got=%0d want=%0d", a.name, rom_addr, a.addr);
      end
    end
    if (out_q.size() > 0) begin
      o = out_q.pop_front();
      checks++;
      if (vout.rgb !== o.rgb || vout.hcount !== o.hc || vout.vcount !== o.vc ||
          vout.hsync !== o.hs || vout.vsync !== o.vs ||
          vout.hblnk !== o.hb || vout.vblnk !== o.vb) begin
        errors++;
        $display("FAIL %s vga_out got rgb=%h h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b want rgb=%h h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b",
                 o.name, vout.rgb, vout.hcount, vout.vcount, vout.hsync, vout.vsync,
                 vout.hblnk, vout.vblnk, o.rgb, o.hc, o.vc, o.hs, o.vs, o.hb, o.vb);
      end
    end
  endtask

  // Drive one pixel per clock. The ROM word attached to the previous pixel
  // is presented now, one clock after that pixel's address was issued.
  task automatic px(input string name, input logic [10:0] hc, input logic [10:0] vc,
                    input logic hb, input logic vb, input logic [11:0] rgb,
                    input logic [11:0] rom, input logic [13:0] ea,
                    input logic [11:0] er, input logic r = 1'b0);
    addr_rec_t a;
    out_rec_t  cur;
    out_rec_t  zero;
    @(negedge clk);
    check_pending();
    rst             = r;
    xpos            = nx;
    ypos            = ny;
    character_state = nst;
    facing          = nf;
    vin.hcount      = hc;
    vin.vcount      = vc;
    vin.hblnk       = hb;
    vin.vblnk       = vb;
    vin.hsync       = 1'($urandom);
    vin.vsync       = vb & 1'($urandom);
    vin.rgb         = rgb;
    rom_data        = prev_rom;
    zero.hc = '0; zero.vc = '0; zero.hs = 1'b0; zero.vs = 1'b0;
    zero.hb = 1'b0; zero.vb = 1'b0; zero.rgb = '0; zero.name = {name, "_rstout"};
    a.name = name;
    if (r) begin
      a.addr = '0;
      addr_q.push_back(a);
      out_q.push_back(zero);
      prev_out = zero;
    end else begin
      a.addr = ea;
      addr_q.push_back(a);
      out_q.push_back(prev_out);
      cur.hc = hc; cur.vc = vc; cur.hs = vin.hsync; cur.vs = vin.vsync;
      cur.hb = hb; cur.vb = vb; cur.rgb = er; cur.name = name;
      prev_out = cur;
    end
    prev_rom = rom;
  endtask

  task automatic vbl(input logic [11:0] x, input logic [11:0] y,
                     input logic [1:0] st, input logic f);
    nx = x; ny = y; nst = st; nf = f;
    px("vbl_edge", 11'd0, 11'd770, 1'b0, 1'b1, 12'h0F0, 12'h000, 14'd0, 12'h0F0);
    px("vbl_hold", 11'd1, 11'd770, 1'b0, 1'b1, 12'h0F1, 12'h000, 14'd0, 12'h0F1);
  endtask

  initial begin
    prev_out.hc = '0; prev_out.vc = '0; prev_out.hs = 1'b0; prev_out.vs = 1'b0;
    prev_out.hb = 1'b0; prev_out.vb = 1'b0; prev_out.rgb = '0; prev_out.name = "init";
    vin.hcount = '0; vin.vcount = '0; vin.hsync = 1'b0; vin.vsync = 1'b0;
    vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = '0;

    //            nf    x        y        st    f     hc         vc        hb    rgb      rom      addr      out rgb
    tbl[0]  = '{1'b1, 12'd100, 12'd200, 2'd0, 1'b1, 11'd100,  11'd200, 1'b0, 12'h111, 12'hABC, 14'd0,    12'hABC};
    tbl[1]  = '{1'b0, 12'd100, 12'd200, 2'd0, 1'b1, 11'd147,  11'd263, 1'b0, 12'h222, 12'hF0F, 14'd3071, 12'h222};
    tbl[2]  = '{1'b0, 12'd100, 12'd200, 2'd0, 1'b1, 11'd99,   11'd200, 1'b0, 12'h333, 12'h777, 14'd0,    12'h333};
    tbl[3]  = '{1'b0, 12'd100, 12'd200, 2'd0, 1'b1, 11'd148,  11'd263, 1'b0, 12'h334, 12'h777, 14'd0,    12'h334};
    tbl[4]  = '{1'b0, 12'd100, 12'd200, 2'd0, 1'b1, 11'd100,  11'd264, 1'b0, 12'h335, 12'h777, 14'd0,    12'h335};
    tbl[5]  = '{1'b0, 12'd100, 12'd200, 2'd0, 1'b1, 11'd120,  11'd230, 1'b0, 12'h111, 12'h2B4, 14'd1460, 12'h2B5};
    tbl[6]  = '{1'b0, 12'd100, 12'd200, 2'd0, 1'b1, 11'd121,  11'd230, 1'b0, 12'h2B4, 12'hF0F, 14'd1461, 12'h2B4};
    tbl[7]  = '{1'b1, 12'd100, 12'd200, 2'd0, 1'b0, 11'd100,  11'd200, 1'b0, 12'h444, 12'h555, 14'd47,   12'h555};
    tbl[8]  = '{1'b0, 12'd100, 12'd200, 2'd0, 1'b0, 11'd147,  11'd200, 1'b0, 12'h444, 12'h556, 14'd0,    12'h556};
    tbl[9]  = '{1'b0, 12'd100, 12'd200, 2'd0, 1'b0, 11'd110,  11'd201, 1'b0, 12'h444, 12'h557, 14'd85,   12'h557};
    tbl[10] = '{1'b1, 12'd1000, 12'd100, 2'd0, 1'b1, 11'd1000, 11'd100, 1'b0, 12'h101, 12'h0AA, 14'd0,    12'h0AA};
    tbl[11] = '{1'b0, 12'd1000, 12'd100, 2'd0, 1'b1, 11'd1023, 11'd100, 1'b0, 12'h102, 12'h0AB, 14'd23,   12'h0AB};
    tbl[12] = '{1'b0, 12'd1000, 12'd100, 2'd0, 1'b1, 11'd1024, 11'd100, 1'b1, 12'h103, 12'h0AC, 14'd0,    12'h103};
    tbl[13] = '{1'b0, 12'd1000, 12'd100, 2'd0, 1'b1, 11'd1030, 11'd100, 1'b1, 12'h104, 12'h0AD, 14'd0,    12'h104};

    // Reset: outputs held at zero.
    for (int i = 0; i < 3; i++)
      px($sformatf("reset%0d", i), 11'd5, 11'd5, 1'b0, 1'b0, 12'hFFF, 12'hFFF, 14'd0, 12'h000, 1'b1);

    // Shadow reset values (x=64, y=641, idle, facing right), no vblank yet.
    px("rst_shadow", 11'd65, 11'd642, 1'b0, 1'b0, 12'h123, 12'h456, 14'd49, 12'h456);

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].nf) vbl(tbl[i].x, tbl[i].y, tbl[i].st, tbl[i].f);
      px($sformatf("tbl%0d", i), tbl[i].hc, tbl[i].vc, tbl[i].hb, 1'b0,
         tbl[i].rgb, tbl[i].rom, tbl[i].ea, tbl[i].er);
    end

    // Walk animation: 8 frames at base 3072, then 8 at base 6144.
    for (int f = 1; f <= 16; f++) begin
      vbl(12'd100, 12'd200, 2'b01, 1'b1);
      px($sformatf("walk_f%0d", f), 11'd101, 11'd200, 1'b0, 1'b0, 12'h010,
         12'h3C3, (f <= 8) ? 14'd3073 : 14'd6145, 12'h3C3);
    end
    vbl(12'd100, 12'd200, 2'b10, 1'b1);
    px("fall_1", 11'd101, 11'd200, 1'b0, 1'b0, 12'h010, 12'h3C4, 14'd9217, 12'h3C4);
    vbl(12'd100, 12'd200, 2'b10, 1'b1);
    px("fall_2", 11'd101, 11'd200, 1'b0, 1'b0, 12'h010, 12'h3C5, 14'd9217, 12'h3C5);
    vbl(12'd100, 12'd200, 2'b11, 1'b1);
    px("reserved", 11'd101, 11'd200, 1'b0, 1'b0, 12'h010, 12'h3C6, 14'd1, 12'h3C6);
    vbl(12'd100, 12'd200, 2'b01, 1'b1);
    px("walk_restart", 11'd101, 11'd200, 1'b0, 1'b0, 12'h010, 12'h3C7, 14'd3073, 12'h3C7);

    // Mid-frame xpos change waits for the next vblank edge.
    vbl(12'd100, 12'd280, 2'b00, 1'b1);
    px("mf_before", 11'd100, 11'd300, 1'b0, 1'b0, 12'h010, 12'h020, 14'd960, 12'h020);
    nx = 12'd300;
    px("mf_old_out", 11'd300, 11'd301, 1'b0, 1'b0, 12'h011, 12'h021, 14'd0, 12'h011);
    px("mf_old_in", 11'd101, 11'd301, 1'b0, 1'b0, 12'h012, 12'h022, 14'd1009, 12'h022);
    vbl(12'd300, 12'd280, 2'b00, 1'b1);
    px("mf_new", 11'd300, 11'd300, 1'b0, 1'b0, 12'h013, 12'h023, 14'd960, 12'h023);
    px("mf_new_out", 11'd101, 11'd301, 1'b0, 1'b0, 12'h014, 12'h024, 14'd0, 12'h014);

    // Change one cycle after the edge is ignored for the whole frame.
    nx = 12'd100;
    px("late_edge", 11'd0, 11'd770, 1'b0, 1'b1, 12'h0F0, 12'h000, 14'd0, 12'h0F0);
    nx = 12'd500;
    px("late_hold", 11'd1, 11'd770, 1'b0, 1'b1, 12'h0F1, 12'h000, 14'd0, 12'h0F1);
    px("late_ignored", 11'd100, 11'd280, 1'b0, 1'b0, 12'h015, 12'h0CC, 14'd0, 12'h0CC);

    // Reset mid-line near the right edge.
    vbl(12'd1000, 12'd100, 2'b00, 1'b1);
    px("pre_rst", 11'd1005, 11'd101, 1'b0, 1'b0, 12'h016, 12'h0DD, 14'd53, 12'h0DD);
    px("rst_mid", 11'd1010, 11'd101, 1'b0, 1'b0, 12'h017, 12'h0DE, 14'd0, 12'h000, 1'b1);
    px("post_rst", 11'd1011, 11'd101, 1'b0, 1'b0, 12'h018, 12'h0DF, 14'd0, 12'h018);
    px("post_rst2", 11'd1012, 11'd101, 1'b0, 1'b0, 12'h019, 12'h0E0, 14'd0, 12'h019);

    @(negedge clk);
    check_pending();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
